vga_image_blitter: RTL
======================

// Module: vga_image_blitter
// PURPOSE
//   Maps the VGA controller's next_x/next_y scan position onto a ROM-stored image and returns the pixel colour.
//   Image position, integer upscale and colour-key transparency are runtime-configurable.
//   Sits between vga_module (coordinates in, color_in out) and the image ROM (address out, q in).
//   Pipeline is latency-matched to the synchronous ROM, so colour and window flag stay aligned.
// PARAMETERS
//   COORD_W   10     width of next_x/next_y and position ports
//   COLOR_W   8      pixel colour width
//   ADDR_W    17     ROM address width
//   IMG_W     320    stored image width, pixels
//   IMG_H     240    stored image height, pixels
//   H_ACTIVE  640    visible pixels per line
//   V_ACTIVE  480    visible lines per frame
//   DEF_X     160    reset value of image left edge
//   DEF_Y     120    reset value of image top edge
//   ROM_LAT   1      ROM read latency, cycles (>=1)
//   KEY_COLOR 8'hE3  transparent colour value
// PORTS
//   clock         in   1        pixel clock (25 MHz)
//   reset         in   1        synchronous, active-high
//   next_x        in   COORD_W  column of next pixel
//   next_y        in   COORD_W  row of next pixel
//   cfg_valid     in   1        config offer
//   cfg_ready     out  1        config slot free
//   cfg_pos_x     in   COORD_W  image left edge, screen pixels
//   cfg_pos_y     in   COORD_W  image top edge, screen pixels
//   cfg_scale     in   2        log2 upscale; 0=1x, 1=2x, 2=4x, 3 treated as 2
//   cfg_key_en    in   1        enable colour-key transparency
//   cfg_bg_color  in   COLOR_W  colour outside image and for keyed pixels
//   rom_address   out  ADDR_W   image ROM address
//   rom_data      in   COLOR_W  image ROM data, ROM_LAT cycles after address
//   color_out     out  COLOR_W  pixel colour, to vga_module color_in
//   in_image      out  1        color_out came from the ROM, not background
// BEHAVIOUR
//   Reset values:
//     - Active regs: pos=DEF_X/DEF_Y, scale=0, key_en=0, bg=0.
//     - Outputs: rom_address=0, color_out=0, in_image=0, cfg_ready=1; pending slot cleared.
//   Window test:
//     - Extent is half-open: pos_x <= x < pos_x+(IMG_W<<scale), pos_y <= y < pos_y+(IMG_H<<scale).
//     - Also requires x < H_ACTIVE and y < V_ACTIVE.
//     - Computed at COORD_W+3 bits; no wrap. Image edges past the screen are clipped.
//   Address:
//     - rom_address = ((y-pos_y)>>scale)*IMG_W + ((x-pos_x)>>scale).
//     - Registered one cycle after next_x/next_y are sampled.
//     - Holds its last value when outside the window.
//   Pipeline: latency from the sampled coordinate to color_out/in_image is exactly 1+ROM_LAT+1 cycles.
//     - Stage 1: address and window flag registered.
//     - ROM_LAT delay stages: window flag, key_en and bg delayed alongside the ROM read.
//     - Output stage: color_out registered.
//   Colour select:
//     - Outside window: color_out=bg, in_image=0.
//     - Keyed: key_en=1 && rom_data==KEY_COLOR gives color_out=bg, in_image=0.
//     - Otherwise: color_out=rom_data, in_image=1.
//   Config handshake:
//     - Offer is accepted when cfg_valid && cfg_ready; the accepted word goes into the pending slot and cfg_ready drops.
//     - Frame start is next_x==0 && next_y==0.
//     - Pending word is copied to the active regs on the first frame start strictly after acceptance; cfg_ready rises the next cycle.
//     - Accept coinciding with a frame start is applied at the following frame start.
//     - Active config never changes mid-frame (no tearing).
//   Reset mid-frame: pipeline flushed to reset values; pending config discarded.
// TESTING
//   1. Default cfg, ROM_LAT=1:
//      (160,120) -> rom_address=0; color_out=rom_data, in_image=1 exactly 3 cycles after sample.
//      (479,359) -> rom_address=76799.
//      (480,120) and (159,120) -> color_out=bg, in_image=0.
//   2. cfg pos=(0,0), scale=1, applied at frame start:
//      (3,5) -> rom_address=641.
//      (639,479) -> rom_address=76799.
//      scale=3 behaves as scale=2: (7,7) -> rom_address=321.
//   3. key_en=1, bg=8'h1C, ROM word 8'hE3 at address 0 -> color_out=8'h1C, in_image=0.
//      key_en=0, same word -> color_out=8'hE3, in_image=1.
//   4. cfg_valid mid-frame with pos=(10,20):
//      cfg_ready=0 next cycle; old position used until (0,0).
//      (10,20) -> rom_address=0 in the new frame; cfg_ready=1 one cycle after frame start.
//   5. cfg_valid during the (0,0) cycle -> not applied this frame; applied at the next (0,0).
//   6. reset asserted mid-window -> next cycle rom_address=0, color_out=0, in_image=0, cfg_ready=1.
//      Pending config lost; DEF_X/DEF_Y active.

Source files
------------

// File: rtl/vga_image_blitter_if.sv
// Configuration handshake bundle for the image blitter: a single-word offer
// (position, scale, colour key, background) with valid/ready flow control.
interface vga_image_blitter_if #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned COLOR_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [COORD_W-1:0] cfg_pos_x;
  logic [COORD_W-1:0] cfg_pos_y;
  logic [1:0]         cfg_scale;
  logic               cfg_key_en;
  logic [COLOR_W-1:0] cfg_bg_color;

  modport master (
    output cfg_valid, cfg_pos_x, cfg_pos_y, cfg_scale, cfg_key_en, cfg_bg_color,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pos_x, cfg_pos_y, cfg_scale, cfg_key_en, cfg_bg_color,
    output cfg_ready
  );
endinterface

// File: rtl/vga_image_blitter.sv
// Maps the VGA scan position onto a ROM-stored image with runtime position,
// integer upscale and colour-key transparency. The colour/window pipeline is
// latency-matched to the synchronous ROM. New configuration is staged in a
// pending slot and only takes effect at a frame start, so a frame never tears.
module vga_image_blitter #(
  parameter int unsigned        COORD_W   = 10,
  parameter int unsigned        COLOR_W   = 8,
  parameter int unsigned        ADDR_W    = 17,
  parameter int unsigned        IMG_W     = 320,
  parameter int unsigned        IMG_H     = 240,
  parameter int unsigned        H_ACTIVE  = 640,
  parameter int unsigned        V_ACTIVE  = 480,
  parameter int unsigned        DEF_X     = 160,
  parameter int unsigned        DEF_Y     = 120,
  parameter int unsigned        ROM_LAT   = 1,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 8'hE3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [COORD_W-1:0]  next_x,
  input  logic [COORD_W-1:0]  next_y,
  vga_image_blitter_if.slave  cfg,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [COLOR_W-1:0]  rom_data,
  output logic [COLOR_W-1:0]  color_out,
  output logic                in_image
);

  // Window arithmetic is widened so pos + (IMG_W << 2) cannot wrap.
  localparam int unsigned WW = COORD_W + 3;

  typedef enum logic [0:0] {StIdle, StPend} cfg_state_e;

  cfg_state_e state_q, state_d;
  logic       cfg_ready;
  logic       accept;
  logic       apply;
  logic       frame_start;

  // Pending slot
  logic [COORD_W-1:0] pend_pos_x_q, pend_pos_y_q;
  logic [1:0]         pend_scale_q;
  logic               pend_key_en_q;
  logic [COLOR_W-1:0] pend_bg_q;

  // Active configuration
  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic [1:0]         scale_q;
  logic               key_en_q;
  logic [COLOR_W-1:0] bg_q;

  // Configuration seen by the pixel being sampled this cycle
  logic [COORD_W-1:0] cur_pos_x, cur_pos_y;
  logic [1:0]         cur_scale, eff_scale;
  logic               cur_key_en;
  logic [COLOR_W-1:0] cur_bg;

  logic [WW-1:0]      x_w, y_w, px_w, py_w, end_x, end_y, dx, dy;
  logic               in_win;
  logic [ADDR_W-1:0]  addr_calc;

  logic [ADDR_W-1:0]                addr_q;
  logic [ROM_LAT:0]                 win_pipe_q;
  logic [ROM_LAT:0]                 key_pipe_q;
  logic [ROM_LAT:0][COLOR_W-1:0]    bg_pipe_q;
  logic [COLOR_W-1:0]               color_d, color_q;
  logic                             img_d, img_q;

  assign frame_start = (next_x == '0) && (next_y == '0);
  assign accept      = cfg.cfg_valid && cfg_ready;
  assign cfg.cfg_ready = cfg_ready;

  // Config FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Config FSM next state: idle until an offer lands, pending until a frame start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg.cfg_valid) state_d = StPend;
      StPend:  if (frame_start)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Config FSM outputs; an offer accepted on a frame start is still in StIdle
  // that cycle, so it naturally waits for the following frame start.
  always_comb begin
    cfg_ready = (state_q == StIdle);
    apply     = (state_q == StPend) && frame_start;
  end

  // Capture the offered word into the pending slot
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_pos_x_q  <= '0;
      pend_pos_y_q  <= '0;
      pend_scale_q  <= '0;
      pend_key_en_q <= 1'b0;
      pend_bg_q     <= '0;
    end else if (accept) begin
      pend_pos_x_q  <= cfg.cfg_pos_x;
      pend_pos_y_q  <= cfg.cfg_pos_y;
      pend_scale_q  <= cfg.cfg_scale;
      pend_key_en_q <= cfg.cfg_key_en;
      pend_bg_q     <= cfg.cfg_bg_color;
    end
  end

  // Promote the pending word to the active registers at frame start
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x_q  <= COORD_W'(DEF_X);
      pos_y_q  <= COORD_W'(DEF_Y);
      scale_q  <= '0;
      key_en_q <= 1'b0;
      bg_q     <= '0;
    end else if (apply) begin
      pos_x_q  <= pend_pos_x_q;
      pos_y_q  <= pend_pos_y_q;
      scale_q  <= pend_scale_q;
      key_en_q <= pend_key_en_q;
      bg_q     <= pend_bg_q;
    end
  end

  // Bypass the pending word on the frame-start pixel so the whole new frame,
  // including (0,0), uses the new configuration.
  always_comb begin
    if (apply) begin
      cur_pos_x  = pend_pos_x_q;
      cur_pos_y  = pend_pos_y_q;
      cur_scale  = pend_scale_q;
      cur_key_en = pend_key_en_q;
      cur_bg     = pend_bg_q;
    end else begin
      cur_pos_x  = pos_x_q;
      cur_pos_y  = pos_y_q;
      cur_scale  = scale_q;
      cur_key_en = key_en_q;
      cur_bg     = bg_q;
    end
    eff_scale = (cur_scale == 2'd3) ? 2'd2 : cur_scale;
  end

  // Window test and ROM address for the sampled coordinate
  always_comb begin
    x_w   = WW'(next_x);
    y_w   = WW'(next_y);
    px_w  = WW'(cur_pos_x);
    py_w  = WW'(cur_pos_y);
    end_x = px_w + (WW'(IMG_W) << eff_scale);
    end_y = py_w + (WW'(IMG_H) << eff_scale);
    in_win = (x_w >= px_w) && (x_w < end_x) && (x_w < WW'(H_ACTIVE)) &&
             (y_w >= py_w) && (y_w < end_y) && (y_w < WW'(V_ACTIVE));
    dx = (x_w - px_w) >> eff_scale;
    dy = (y_w - py_w) >> eff_scale;
    addr_calc = ADDR_W'(dy) * ADDR_W'(IMG_W) + ADDR_W'(dx);
  end

  // Stage 1 plus ROM_LAT delay stages for the side-band that rides with the read
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      win_pipe_q <= '0;
      key_pipe_q <= '0;
      bg_pipe_q  <= '0;
    end else begin
      if (in_win) addr_q <= addr_calc;
      win_pipe_q <= {win_pipe_q[ROM_LAT-1:0], in_win};
      key_pipe_q <= {key_pipe_q[ROM_LAT-1:0], cur_key_en};
      bg_pipe_q  <= {bg_pipe_q[ROM_LAT-1:0], cur_bg};
    end
  end

  // Colour select: background outside the window or on a keyed pixel
  always_comb begin
    color_d = bg_pipe_q[ROM_LAT];
    img_d   = 1'b0;
    if (win_pipe_q[ROM_LAT] && !(key_pipe_q[ROM_LAT] && (rom_data == KEY_COLOR))) begin
      color_d = rom_data;
      img_d   = 1'b1;
    end
  end

  // Output stage register
  always_ff @(posedge clock) begin
    if (reset) begin
      color_q <= '0;
      img_q   <= 1'b0;
    end else begin
      color_q <= color_d;
      img_q   <= img_d;
    end
  end

  assign rom_address = addr_q;
  assign color_out   = color_q;
  assign in_image    = img_q;

endmodule
